// File: rtl/intt_result_collector.sv
// INTT result collector.
// Captures INTT output rows in any order into a row-wide store. When every row
// has been written once, it streams all N coefficients in ascending index order
// on a valid/ready interface, then returns to collecting.
module intt_result_collector #(
    parameter int unsigned LOG_CORE_COUNT = 4,
    parameter int unsigned LOG_N          = 12
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_active,
    input  logic [8:0]                                    in_address,
    input  logic [(1 << LOG_CORE_COUNT)-1:0][1:0][59:0]   in_data,
    output logic [29:0]                                   m_data,
    output logic [LOG_N-1:0]                              m_index,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic                                          m_last,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          overrun,
    output logic                                          addr_err
);

    localparam int unsigned CORES      = 1 << LOG_CORE_COUNT;
    localparam int unsigned COEF_W     = 30;
    localparam int unsigned COEF_BITS  = LOG_CORE_COUNT + 2;
    localparam int unsigned ROW_COEFFS = 4 * CORES;
    localparam int unsigned N          = 1 << LOG_N;
    localparam int unsigned ROW_BITS   = LOG_N - COEF_BITS;
    localparam int unsigned ROWS       = N / ROW_COEFFS;
    localparam int unsigned CNT_W      = ROW_BITS + 1;
    localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DRAIN   = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Row store: coefficient o of a row sits at bit 30*o, matching the in_data layout.
    logic [ROW_COEFFS-1:0][COEF_W-1:0] r_mem [ROWS];

    logic [ROWS-1:0]     r_written;
    logic [CNT_W-1:0]    r_count;
    logic [LOG_N-1:0]    r_rd_idx;
    logic                r_issue_done;
    logic                r_s1_valid;
    logic [COEF_W-1:0]   r_s1_data;
    logic [LOG_N-1:0]    r_s1_idx;
    logic                r_m_valid;
    logic [COEF_W-1:0]   r_m_data;
    logic [LOG_N-1:0]    r_m_index;
    logic                r_m_last;
    logic                r_busy;
    logic                r_done;
    logic                r_overrun;
    logic                r_addr_err;

    logic                w_in_range;
    logic [ROW_BITS-1:0] w_wr_row;
    logic [COEF_W-1:0]   w_rd_coef;
    logic                w_wr_en;
    logic                w_new_row;
    logic                w_fill_done;
    logic                w_adv;
    logic                w_issue;
    logic                w_final;
    logic                w_ovr_hit;

    assign w_in_range = (32'(in_address) < ROWS);
    assign w_wr_row   = in_address[ROW_BITS-1:0];
    assign w_rd_coef  = r_mem[r_rd_idx[LOG_N-1 -: ROW_BITS]][r_rd_idx[COEF_BITS-1:0]];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: drain once all rows are present, collect again after the last beat.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COLLECT: if (w_fill_done) w_state_nxt = ST_DRAIN;
            ST_DRAIN:   if (w_final)     w_state_nxt = ST_COLLECT;
            default:    w_state_nxt = ST_COLLECT;
        endcase
    end

    // Per-state strobes; the whole read pipeline advances when the output slot is free.
    always_comb begin
        w_wr_en   = 1'b0;
        w_ovr_hit = 1'b0;
        w_issue   = 1'b0;
        w_adv     = !r_m_valid || m_ready;
        w_final   = r_m_valid && m_ready && r_m_last;
        case (r_state)
            ST_COLLECT: w_wr_en = in_active && w_in_range;
            ST_DRAIN: begin
                w_ovr_hit = in_active;
                w_issue   = w_adv && !r_issue_done;
            end
            default: ;
        endcase
        w_new_row   = w_wr_en && !r_written[w_wr_row];
        w_fill_done = w_new_row && (r_count == CNT_W'(ROWS - 1));
    end

    // Row capture; storage content is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_row] <= in_data;
        end
    end

    // Written-row bookkeeping, status flags and busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_written  <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_done <= w_final;
            r_busy <= (w_state_nxt == ST_DRAIN);
            if (in_active && !w_in_range) r_addr_err <= 1'b1;
            if (w_ovr_hit)                r_overrun  <= 1'b1;
            if (w_final) begin
                r_written <= '0;
                r_count   <= '0;
            end else if (w_new_row) begin
                r_written[w_wr_row] <= 1'b1;
                r_count             <= r_count + 1'b1;
            end
        end
    end

    // Two-stage read pipeline: issue pointer -> stage 1 -> output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_idx     <= '0;
            r_issue_done <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_data    <= '0;
            r_s1_idx     <= '0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_index    <= '0;
            r_m_last     <= 1'b0;
        end else begin
            if (w_fill_done) begin
                r_rd_idx     <= '0;
                r_issue_done <= 1'b0;
            end else if (w_issue) begin
                r_rd_idx <= r_rd_idx + 1'b1;
                if (r_rd_idx == LAST_IDX) r_issue_done <= 1'b1;
            end
            if (w_issue) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= w_rd_coef;
                r_s1_idx   <= r_rd_idx;
            end else if (w_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_adv) begin
                r_m_valid <= r_s1_valid;
                r_m_data  <= r_s1_data;
                r_m_index <= r_s1_idx;
                r_m_last  <= r_s1_valid && (r_s1_idx == LAST_IDX);
            end
        end
    end

    assign m_data   = r_m_data;
    assign m_index  = r_m_index;
    assign m_valid  = r_m_valid;
    assign m_last   = r_m_last;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overrun  = r_overrun;
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_intt_result_collector.sv
// Bench for intt_result_collector: random row data, reference store indexed by
// coefficient number, drained stream compared beat by beat.
module tb_intt_result_collector;

    localparam int NCOEF = 4096;
    localparam int NROWS = 64;
    localparam int RCOEF = 64;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_active;
    logic [8:0]              in_address;
    logic [15:0][1:0][59:0]  in_data;
    logic [29:0]             m_data;
    logic [11:0]             m_index;
    logic                    m_valid;
    logic                    m_ready;
    logic                    m_last;
    logic                    busy;
    logic                    done;
    logic                    overrun;
    logic                    addr_err;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [29:0] exp_mem [NCOEF];
    logic        exp_ovr  = 1'b0;
    logic        exp_aerr = 1'b0;
    logic [29:0] obs320;

    intt_result_collector dut (
        .clk       (clk),
        .rst       (rst),
        .in_active (in_active),
        .in_address(in_address),
        .in_data   (in_data),
        .m_data    (m_data),
        .m_index   (m_index),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun),
        .addr_err  (addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0][29:0] rand_row();
        logic [63:0][29:0] r;
        for (int o = 0; o < RCOEF; o++) r[o] = 30'($urandom);
        return r;
    endfunction

    function automatic logic [63:0][29:0] idx_row(input int a);
        logic [63:0][29:0] r;
        for (int o = 0; o < RCOEF; o++) r[o] = 30'(a * RCOEF + o);
        return r;
    endfunction

    // One strobe cycle; the reference store follows the capture rules.
    task automatic cap(input int a, input logic [63:0][29:0] rv);
        in_active  = 1'b1;
        in_address = 9'(a);
        in_data    = rv;
        @(posedge clk); #1;
        in_active  = 1'b0;
        if (a < NROWS) begin
            for (int o = 0; o < RCOEF; o++) exp_mem[a * RCOEF + o] = rv[o];
        end else begin
            exp_aerr = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called right after the edge that captured the final distinct row.
    task automatic drain(input bit rand_ready, input int ovr_at, input int rst_at, input int cap_at_done);
        int          k      = 0;
        int          cyc    = 0;
        int          first  = -1;
        bit          ovr_dn = 1'b0;
        logic        prev_stall = 1'b0;
        logic [42:0] held   = '0;
        logic [42:0] got;
        while (k < NCOEF && cyc < 20000) begin
            m_ready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            in_active = 1'b0;
            if (k == ovr_at && !ovr_dn) begin
                in_active  = 1'b1;
                in_address = 9'd3;
                in_data    = rand_row();
                ovr_dn     = 1'b1;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_mid_drain_outs",
                      {m_valid, m_last, m_data, m_index, busy, done, overrun, addr_err}, 64'd0);
                exp_ovr  = 1'b0;
                exp_aerr = 1'b0;
                @(posedge clk); #1;
                rst       = 1'b0;
                m_ready   = 1'b0;
                return;
            end
            @(negedge clk);
            got = {m_last, m_index, m_data};
            if (prev_stall) check("stall_hold", {m_valid, got}, {1'b1, held});
            if (m_valid) begin
                if (first < 0) begin
                    first = cyc;
                    check("first_beat_latency", 64'(first), 64'd2);
                end
                check("beat", 64'(got), 64'({k == NCOEF - 1, 12'(k), exp_mem[k]}));
                if (k == 320) obs320 = m_data;
                if (m_ready) k++;
            end
            prev_stall = m_valid && !m_ready;
            held       = got;
            @(posedge clk); #1;
            cyc++;
        end
        in_active = 1'b0;
        if (k < NCOEF) begin
            check("drain_timeout", 64'(k), 64'(NCOEF));
            return;
        end
        m_ready = 1'b0;
        @(negedge clk);
        check("done_pulse", {done, busy, m_valid}, 3'b100);
        if (cap_at_done >= 0) cap(cap_at_done, rand_row());
        else idle(1);
        @(negedge clk);
        check("done_clear", {done, busy}, 2'b00);
        @(posedge clk); #1;
    endtask

    task automatic check_flags(input string tag);
        check(tag, {overrun, addr_err}, {exp_ovr, exp_aerr});
    endtask

    initial begin
        logic [63:0][29:0] rv;
        int nvalid;
        rst = 1'b1; in_active = 1'b0; in_address = '0; in_data = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {m_valid, m_last, m_data, m_index, busy, done, overrun, addr_err}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // In-order contiguous burst, value equals index.
        for (int a = 0; a < NROWS; a++) begin
            if (a == NROWS - 1) check("busy_before_last_row", 64'(busy), 64'd0);
            cap(a, idx_row(a));
        end
        drain(1'b0, -1, -1, -1);
        check_flags("flags_after_inorder");

        // Out-of-range address, then reverse order with idle gaps.
        cap(100, rand_row());
        idle(1);
        check_flags("addr_err_set");
        for (int a = NROWS - 1; a >= 0; a--) begin
            cap(a, idx_row(a));
            if (a != 0) idle(1);
        end
        drain(1'b0, -1, -1, -1);

        // Duplicate row 5, random backpressure; row 7 captured in the done cycle.
        for (int a = 0; a < NROWS; a++) begin
            cap(a, rand_row());
            if (a == 5) begin
                rv    = rand_row();
                rv[0] = 30'h1234567;
                cap(5, rv);
            end
            if (a == NROWS - 2) check("busy_after_dup", 64'(busy), 64'd0);
        end
        drain(1'b1, -1, -1, 7);
        check("dup_index320", 64'(obs320), 64'h1234567);

        // Remaining 63 rows, overrun strobe at beat 1000.
        for (int a = 0; a < NROWS; a++) if (a != 7) cap(a, rand_row());
        drain(1'b1, 1000, -1, -1);
        exp_ovr = 1'b1;
        check_flags("overrun_set");

        // Reset at beat 2000, then a fresh capture is needed before draining.
        for (int a = 0; a < NROWS; a++) cap(a, rand_row());
        drain(1'b0, -1, 2000, -1);
        m_ready = 1'b1;
        nvalid  = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_valid || busy) nvalid++;
            @(posedge clk); #1;
        end
        check("no_beats_after_reset", 64'(nvalid), 64'd0);
        check_flags("flags_cleared_by_reset");
        for (int a = NROWS - 2; a >= 0; a--) cap(a, rand_row());
        nvalid = 0;
        repeat (5) begin
            @(negedge clk);
            if (m_valid || busy) nvalid++;
            @(posedge clk); #1;
        end
        check("no_drain_on_63_rows", 64'(nvalid), 64'd0);
        cap(NROWS - 1, rand_row());
        drain(1'b0, -1, -1, -1);
        check_flags("flags_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
